tinker_loader: RTL and testbench



---
 rtl/tinker_pkg.sv | 19 +
 rtl/tinker_loader_if.sv | 23 ++
 rtl/tinker_byte_packer.sv | 53 +++++
 rtl/tinker_loader.sv | 142 ++++++++++++++
 tb/tb_tinker_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tinker_pkg.sv
// Shared Tinker definitions: loader FSM encoding, memory geometry and reset PC.
package tinker_pkg;

    localparam int unsigned WORD_W     = 64;
    localparam int unsigned BYTE_LANES = 8;

    localparam logic [63:0] TINKER_MEM_BYTES = 64'd524288;
    localparam logic [63:0] TINKER_RESET_PC  = 64'h2000;

    typedef enum logic [2:0] {
        HDR_ADDR = 3'd0,
        HDR_LEN  = 3'd1,
        PAYLOAD  = 3'd2,
        CHECK    = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } loader_state_t;

endpackage

// File: rtl/tinker_loader_if.sv
// Byte stream in, byte-masked memory write port out.
interface tinker_loader_if;
    import tinker_pkg::*;

    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [WORD_W-1:0]     mem_addr;
    logic [WORD_W-1:0]     mem_wdata;
    logic [BYTE_LANES-1:0] mem_wmask;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/tinker_byte_packer.sv
// Packs bytes little-endian into a word; a full word or a flush moves it to the
// staging register so the next byte can land in the same cycle.
module tinker_byte_packer
    import tinker_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    input  logic                  flush,
    output logic [WORD_W-1:0]     word,
    output logic [BYTE_LANES-1:0] mask,
    output logic                  word_valid
);

    localparam int unsigned LANE_W = $clog2(BYTE_LANES);

    logic [LANE_W-1:0]     lane_q;
    logic [WORD_W-1:0]     pack_q;
    logic [WORD_W-1:0]     pack_c;
    logic [BYTE_LANES-1:0] mask_c;
    logic                  complete_c;

    // Current byte merged into its lane; mask covers lanes 0..lane.
    always_comb begin
        pack_c = pack_q;
        pack_c[{lane_q, 3'b000} +: 8] = byte_data;
        mask_c     = BYTE_LANES'((16'd2 << lane_q) - 16'd1);
        complete_c = byte_valid && ((lane_q == LANE_W'(BYTE_LANES - 1)) || flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q     <= '0;
            pack_q     <= '0;
            word       <= '0;
            mask       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= complete_c;
            if (complete_c) begin
                word   <= pack_c;
                mask   <= mask_c;
                pack_q <= '0;
                lane_q <= '0;
            end else if (byte_valid) begin
                pack_q <= pack_c;
                lane_q <= lane_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tinker_loader.sv
// Boot loader: parses {base, length, payload, xor checksum} from a byte stream,
// writes the payload to memory and releases the core once the checksum matches.
module tinker_loader
    import tinker_pkg::*;
#(
    parameter logic [63:0] MEM_BYTES    = TINKER_MEM_BYTES,
    parameter logic [63:0] DEFAULT_BASE = TINKER_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    tinker_loader_if.slave       bus,
    input  logic                 restart,
    output logic                 core_reset,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          bytes_loaded
);

    localparam logic [2:0] S_HDR_ADDR = 3'(HDR_ADDR);
    localparam logic [2:0] S_HDR_LEN  = 3'(HDR_LEN);
    localparam logic [2:0] S_PAYLOAD  = 3'(PAYLOAD);
    localparam logic [2:0] S_CHECK    = 3'(CHECK);
    localparam logic [2:0] S_DONE     = 3'(DONE);
    localparam logic [2:0] S_ERROR    = 3'(ERROR);

    logic [2:0]  state_q, state_d;
    logic [2:0]  hdr_cnt_q;
    logic [63:0] base_q;
    logic [31:0] len_q;
    logic [31:0] pay_idx_q;
    logic [7:0]  csum_q;
    logic        in_ready_q;
    logic [63:0] mem_addr_q;

    logic        accept_c;
    logic        last_c;
    logic        hdr_bad_c;
    logic        pack_strobe_c;
    logic [63:0] base_next_c;
    logic [31:0] len_full_c;
    logic [64:0] end_addr_c;

    assign accept_c      = bus.in_valid && in_ready_q;
    assign base_next_c   = {bus.in_data, base_q[63:8]};
    assign len_full_c    = {bus.in_data, len_q[31:8]};
    assign last_c        = (pay_idx_q == len_q - 32'd1);
    // Bounds check at 65 bits so a huge base cannot wrap past the limit.
    assign end_addr_c    = {1'b0, base_q} + 65'(len_full_c);
    assign hdr_bad_c     = (base_q[2:0] != 3'd0) || (end_addr_c > {1'b0, MEM_BYTES});
    assign pack_strobe_c = accept_c && (state_q == S_PAYLOAD);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_ADDR: if (accept_c && hdr_cnt_q == 3'd7) state_d = S_HDR_LEN;
            S_HDR_LEN: begin
                if (accept_c && hdr_cnt_q == 3'd3) begin
                    if (hdr_bad_c)                state_d = S_ERROR;
                    else if (len_full_c == 32'd0) state_d = S_CHECK;
                    else                          state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD:  if (accept_c && last_c) state_d = S_CHECK;
            S_CHECK:    if (accept_c) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERROR;
            S_DONE,
            S_ERROR:    if (restart) state_d = S_HDR_ADDR;
            default:    state_d = S_HDR_ADDR;
        endcase
    end

    // State register and state-derived outputs, all aligned to the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_HDR_ADDR;
            in_ready_q <= 1'b1;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_DONE) && (state_d != S_ERROR);
            core_reset <= (state_d != S_DONE);
            done       <= (state_d == S_DONE);
            error      <= (state_d == S_ERROR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt_q    <= '0;
            base_q       <= '0;
            len_q        <= '0;
            pay_idx_q    <= '0;
            csum_q       <= '0;
            bytes_loaded <= '0;
            mem_addr_q   <= '0;
        end else begin
            if (accept_c) begin
                case (state_q)
                    S_HDR_ADDR: begin
                        hdr_cnt_q <= hdr_cnt_q + 3'd1;
                        base_q    <= (hdr_cnt_q == 3'd7 && base_next_c == '1) ? DEFAULT_BASE
                                                                            : base_next_c;
                    end
                    S_HDR_LEN: begin
                        hdr_cnt_q <= (hdr_cnt_q == 3'd3) ? 3'd0 : hdr_cnt_q + 3'd1;
                        len_q     <= len_full_c;
                        pay_idx_q <= '0;
                    end
                    S_PAYLOAD: begin
                        pay_idx_q <= pay_idx_q + 32'd1;
                        csum_q    <= csum_q ^ bus.in_data;
                        if (bytes_loaded != '1) bytes_loaded <= bytes_loaded + 32'd1;
                        if (pay_idx_q[2:0] == 3'd7 || last_c)
                            mem_addr_q <= base_q + 64'({pay_idx_q[31:3], 3'b000});
                    end
                    default: ;
                endcase
            end
            if (restart && (state_q == S_DONE || state_q == S_ERROR)) begin
                hdr_cnt_q    <= '0;
                csum_q       <= '0;
                bytes_loaded <= '0;
            end
        end
    end

    tinker_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (pack_strobe_c),
        .byte_data  (bus.in_data),
        .flush      (last_c),
        .word       (bus.mem_wdata),
        .mask       (bus.mem_wmask),
        .word_valid (bus.mem_we)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_tinker_loader.sv
// Bench for tinker_loader: directed frame table, reset/restart sequences and
// random frames checked against a frame-level reference model.
module tb_tinker_loader;
    import tinker_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        restart;
    logic        core_reset;
    logic        done;
    logic        error;
    logic [31:0] bytes_loaded;

    tinker_loader_if bus();

    tinker_loader dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .restart      (restart),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .bytes_loaded (bytes_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [7:0]  mask;
    } wr_t;

    typedef struct {
        logic [63:0] base;
        int          n;
        int          pat;
        logic [7:0]  csum;
        bit          exp_done;
        bit          exp_error;
        int          exp_writes;
        logic [63:0] w0_data;
        logic [7:0]  w0_mask;
    } vec_t;

    int  errors = 0;
    int  checks = 0;
    int  acc_n = 0;
    int  valid_n = 0;
    wr_t got_q[$];
    wr_t exp_q[$];

    always @(negedge clk) begin
        if (bus.mem_we) got_q.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_wmask});
    end

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.in_valid) valid_n <= valid_n + 1;
            if (bus.in_valid && bus.in_ready) acc_n <= acc_n + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        restart = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; leaves in_valid high so consecutive calls stream gap-free.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic pulse_restart_and_check();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_bytes", 64'(bytes_loaded), 64'd0);
    endtask

    // Sends one frame and checks writes and final status against the model.
    task automatic run_frame(input logic [63:0] base, input int n, input int pat,
                             input bit csum_given, input logic [7:0] csum_val,
                             input int max_gap, input bit mid_restart);
        logic [7:0]  pl[$];
        logic [63:0] eff;
        logic [64:0] end_addr;
        logic [7:0]  x;
        logic [7:0]  csum;
        bit          hdr_ok;
        int          a0, v0, total;
        pl.delete();
        for (int k = 0; k < n; k++) begin
            if (pat == 0)      pl.push_back(8'(k));
            else if (pat == 1) pl.push_back(8'(8'hAA + 8'h11 * k));
            else               pl.push_back(8'($urandom));
        end
        eff      = (base == '1) ? 64'h2000 : base;
        end_addr = {1'b0, eff} + 65'(n);
        hdr_ok   = (eff % 8 == 0) && (end_addr <= 65'd524288);
        x = 8'h00;
        foreach (pl[k]) x ^= pl[k];
        csum = csum_given ? csum_val : x;
        exp_q.delete();
        if (hdr_ok) begin
            for (int w = 0; w * 8 < n; w++) begin
                wr_t e;
                e.addr = eff + 64'(w * 8);
                e.data = '0;
                e.mask = '0;
                for (int j = 0; j < 8; j++) begin
                    if (w * 8 + j < n) begin
                        e.data |= 64'(pl[w * 8 + j]) << (8 * j);
                        e.mask |= 8'(1 << j);
                    end
                end
                exp_q.push_back(e);
            end
        end
        got_q.delete();
        a0 = acc_n;
        v0 = valid_n;
        for (int i = 0; i < 8; i++) send_byte(8'(base >> (8 * i)));
        for (int i = 0; i < 4; i++) send_byte(8'(32'(n) >> (8 * i)));
        if (hdr_ok) begin
            for (int k = 0; k < n; k++) begin
                if (max_gap > 0) begin
                    int g = $urandom_range(0, max_gap);
                    if (g > 0) begin
                        bus.in_valid = 1'b0;
                        repeat (g) @(negedge clk);
                    end
                end
                if (mid_restart && k == n / 2) restart = 1'b1;
                send_byte(pl[k]);
                restart = 1'b0;
            end
            send_byte(csum);
        end
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("wr%0d_addr", i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("wr%0d_data", i), got_q[i].data, exp_q[i].data);
            check($sformatf("wr%0d_mask", i), 64'(got_q[i].mask), 64'(exp_q[i].mask));
        end
        check("done", 64'(done), 64'(hdr_ok && csum == x));
        check("error", 64'(error), 64'(!(hdr_ok && csum == x)));
        check("core_reset", 64'(core_reset), 64'(!(hdr_ok && csum == x)));
        check("in_ready_end", 64'(bus.in_ready), 64'd0);
        check("bytes_loaded", 64'(bytes_loaded), hdr_ok ? 64'(n) : 64'd0);
        if (max_gap == 0 && !mid_restart) begin
            total = 12 + (hdr_ok ? n + 1 : 0);
            check("accepted_total", 64'(acc_n - a0), 64'(total));
            check("valid_cycles", 64'(valid_n - v0), 64'(total));
        end
    endtask

    vec_t tab[9];

    initial begin
        tab[0] = '{64'h2000,  16, 0, 8'h00, 1'b1, 1'b0, 2, 64'h0706050403020100, 8'hFF};
        tab[1] = '{'1,         3, 1, 8'hDD, 1'b1, 1'b0, 1, 64'h0000000000CCBBAA, 8'h07};
        tab[2] = '{64'h2004,   4, 0, 8'h00, 1'b0, 1'b1, 0, 64'h0, 8'h00};
        tab[3] = '{64'h7FFF8, 16, 0, 8'h00, 1'b0, 1'b1, 0, 64'h0, 8'h00};
        tab[4] = '{64'h2000,   8, 0, 8'h01, 1'b0, 1'b1, 1, 64'h0706050403020100, 8'hFF};
        tab[5] = '{64'h3000,   0, 0, 8'h00, 1'b1, 1'b0, 0, 64'h0, 8'h00};
        tab[6] = '{64'h7FFF8,  8, 0, 8'h00, 1'b1, 1'b0, 1, 64'h0706050403020100, 8'hFF};
        tab[7] = '{64'h7FFF8,  9, 0, 8'h00, 1'b0, 1'b1, 0, 64'h0, 8'h00};
        tab[8] = '{64'h10,    13, 0, 8'h0C, 1'b1, 1'b0, 2, 64'h0706050403020100, 8'hFF};

        do_reset();
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_mem_we", 64'(bus.mem_we), 64'd0);
        check("reset_mem_addr", bus.mem_addr, 64'd0);
        check("reset_mem_wdata", bus.mem_wdata, 64'd0);
        check("reset_mem_wmask", 64'(bus.mem_wmask), 64'd0);
        check("reset_core_reset", 64'(core_reset), 64'd1);
        check("reset_done", 64'(done), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        check("reset_bytes", 64'(bytes_loaded), 64'd0);

        for (int i = 0; i < 9; i++) begin
            run_frame(tab[i].base, tab[i].n, tab[i].pat, 1'b1, tab[i].csum, i % 2, 1'b0);
            check($sformatf("tab%0d_done", i), 64'(done), 64'(tab[i].exp_done));
            check($sformatf("tab%0d_error", i), 64'(error), 64'(tab[i].exp_error));
            check($sformatf("tab%0d_writes", i), 64'(got_q.size()), 64'(tab[i].exp_writes));
            if (tab[i].exp_writes > 0 && got_q.size() > 0) begin
                check($sformatf("tab%0d_w0_data", i), got_q[0].data, tab[i].w0_data);
                check($sformatf("tab%0d_w0_mask", i), 64'(got_q[0].mask), 64'(tab[i].w0_mask));
            end
            pulse_restart_and_check();
        end

        // Reset arriving with payload byte 5 on the bus aborts the frame silently.
        got_q.delete();
        for (int i = 0; i < 8; i++) send_byte(8'(64'h2000 >> (8 * i)));
        for (int i = 0; i < 4; i++) send_byte(8'(32'd16 >> (8 * i)));
        for (int k = 0; k < 5; k++) send_byte(8'(8'h50 + k));
        bus.in_data = 8'h55;
        reset = 1'b1;
        @(negedge clk);
        check("abort_core_reset", 64'(core_reset), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_write", 64'(got_q.size()), 64'd0);
        check("abort_bytes", 64'(bytes_loaded), 64'd0);
        check("abort_core_reset_after", 64'(core_reset), 64'd1);
        run_frame(64'h4000, 21, 2, 1'b0, 8'h00, 0, 1'b0);
        pulse_restart_and_check();

        // Random frames with gaps, occasional bad checksum and ignored mid-frame restart.
        for (int r = 0; r < 10; r++) begin
            logic [63:0] base;
            int          n;
            bit          bad;
            n = $urandom_range(0, 40);
            if ($urandom_range(0, 3) == 0) base = 64'h7FFF8 - 64'(8 * $urandom_range(0, 4));
            else                           base = 64'($urandom_range(0, 16'hFFFF)) << 3;
            if ($urandom_range(0, 7) == 0) base = base | 64'h3;
            bad = ($urandom_range(0, 4) == 0);
            if (bad) run_frame(base, n, 2, 1'b1, 8'($urandom_range(0, 255)), 2, r[0]);
            else     run_frame(base, n, 2, 1'b0, 8'h00, 2, r[0]);
            pulse_restart_and_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
